// File: rtl/ofdm_map_seq.sv
// rtl/ofdm_map_seq.sv - double-banked subcarrier-map sequencer streaming per-subcarrier class codes
// Scans one symbol per start; the shadow bank is swapped in only between symbols.
module ofdm_map_seq #(
  parameter int FFTSIZE  = 1024,
  parameter int ADDR_W   = 10,
  parameter int NUM_BW   = 6,
  parameter int CLS_W    = 2,
  parameter int BW_W     = 3,
  parameter     MAP_INIT = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BW_W-1:0]          bw_idx,
  output logic                     busy,
  output logic                     start_err,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NUM_BW*CLS_W-1:0]  cfg_wdata,
  input  logic                     cfg_commit,
  output logic                     commit_pend,
  output logic                     active_bank,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [CLS_W-1:0]         o_cls,
  output logic [ADDR_W-1:0]        o_addr,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic                     stat_valid,
  output logic [ADDR_W:0]          stat_data,
  output logic [ADDR_W:0]          stat_pilot,
  output logic [ADDR_W:0]          stat_null
);

  localparam int WORD_W = NUM_BW * CLS_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFTSIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  logic [WORD_W-1:0] bank0 [FFTSIZE];
  logic [WORD_W-1:0] bank1 [FFTSIZE];
  logic [WORD_W-1:0] rd_word_q;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                start_err_q, start_err_d;
  logic [BW_W-1:0]     bw_q, bw_d;
  logic                scan_bank_q, scan_bank_d;
  logic                active_bank_q, active_bank_d;
  logic                commit_pend_q, commit_pend_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                s1_v_q, s1_v_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                o_valid_q, o_valid_d;
  logic [CLS_W-1:0]    o_cls_q, o_cls_d;
  logic [ADDR_W-1:0]   o_addr_q, o_addr_d;
  logic                o_sop_q, o_sop_d;
  logic                o_eop_q, o_eop_d;
  logic [CNT_W-1:0]    cnt_data_q, cnt_data_d;
  logic [CNT_W-1:0]    cnt_pilot_q, cnt_pilot_d;
  logic [CNT_W-1:0]    cnt_null_q, cnt_null_d;
  logic                stat_valid_q, stat_valid_d;
  logic [CNT_W-1:0]    stat_data_q, stat_data_d;
  logic [CNT_W-1:0]    stat_pilot_q, stat_pilot_d;
  logic [CNT_W-1:0]    stat_null_q, stat_null_d;

  logic              bw_ok, start_ok, out_free, out_fire, eop_fire, s1_move, issue, rd_bank, swap;
  logic [ADDR_W-1:0] issue_addr;
  logic [CLS_W-1:0]  s1_cls;

  // Address 0 is read in the start cycle itself so the first beat lands two cycles later.
  assign bw_ok      = 32'(bw_idx) < NUM_BW;
  assign start_ok   = (state_q == S_IDLE) && start && bw_ok;
  assign out_free   = !o_valid_q || o_ready;
  assign out_fire   = o_valid_q && o_ready;
  assign eop_fire   = out_fire && o_eop_q;
  assign s1_move    = s1_v_q && out_free;
  assign issue      = start_ok || ((state_q == S_RUN) && (!s1_v_q || out_free));
  assign issue_addr = start_ok ? '0 : rd_ptr_q;
  assign rd_bank    = (state_q == S_IDLE) ? active_bank_q : scan_bank_q;
  assign s1_cls     = rd_word_q[int'(bw_q) * CLS_W +: CLS_W];
  // An idle swap yields to a start unless it is the stat_valid cycle, where the start keeps the old bank.
  assign swap       = commit_pend_q && (state_q == S_IDLE) && (stat_valid_q || !start);

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      if (active_bank_q) bank0[cfg_addr] <= cfg_wdata;
      else               bank1[cfg_addr] <= cfg_wdata;
    end
    if (issue) rd_word_q <= rd_bank ? bank1[issue_addr] : bank0[issue_addr];
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    start_err_d   = 1'b0;
    bw_d          = bw_q;
    scan_bank_d   = scan_bank_q;
    active_bank_d = active_bank_q;
    commit_pend_d = commit_pend_q | cfg_commit;
    rd_ptr_d      = rd_ptr_q;
    s1_v_d        = s1_v_q;
    s1_addr_d     = s1_addr_q;
    o_valid_d     = o_valid_q;
    o_cls_d       = o_cls_q;
    o_addr_d      = o_addr_q;
    o_sop_d       = o_sop_q;
    o_eop_d       = o_eop_q;
    cnt_data_d    = cnt_data_q;
    cnt_pilot_d   = cnt_pilot_q;
    cnt_null_d    = cnt_null_q;
    stat_valid_d  = 1'b0;
    stat_data_d   = stat_data_q;
    stat_pilot_d  = stat_pilot_q;
    stat_null_d   = stat_null_q;

    if (swap) begin
      active_bank_d = ~active_bank_q;
      commit_pend_d = 1'b0;
    end

    if (out_fire) begin
      case (o_cls_q)
        CLS_W'(1): cnt_data_d  = cnt_data_q + CNT_W'(1);
        CLS_W'(2): cnt_pilot_d = cnt_pilot_q + CNT_W'(1);
        default:   cnt_null_d  = cnt_null_q + CNT_W'(1);
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!bw_ok) begin
            start_err_d = 1'b1;
          end else begin
            state_d     = S_RUN;
            busy_d      = 1'b1;
            bw_d        = bw_idx;
            scan_bank_d = active_bank_q;
            rd_ptr_d    = ADDR_W'(1);
            cnt_data_d  = '0;
            cnt_pilot_d = '0;
            cnt_null_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          if (rd_ptr_q == LAST_ADDR) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (eop_fire) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          stat_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (eop_fire) begin
      stat_data_d  = cnt_data_d;
      stat_pilot_d = cnt_pilot_d;
      stat_null_d  = cnt_null_d;
    end

    if (issue) begin
      s1_v_d    = 1'b1;
      s1_addr_d = issue_addr;
    end else if (s1_move) begin
      s1_v_d = 1'b0;
    end

    if (s1_move) begin
      o_valid_d = 1'b1;
      o_cls_d   = s1_cls;
      o_addr_d  = s1_addr_q;
      o_sop_d   = (s1_addr_q == '0);
      o_eop_d   = (s1_addr_q == LAST_ADDR);
    end else if (out_fire) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      start_err_q   <= 1'b0;
      bw_q          <= '0;
      scan_bank_q   <= 1'b0;
      active_bank_q <= 1'b0;
      commit_pend_q <= 1'b0;
      rd_ptr_q      <= '0;
      s1_v_q        <= 1'b0;
      s1_addr_q     <= '0;
      o_valid_q     <= 1'b0;
      o_cls_q       <= '0;
      o_addr_q      <= '0;
      o_sop_q       <= 1'b0;
      o_eop_q       <= 1'b0;
      cnt_data_q    <= '0;
      cnt_pilot_q   <= '0;
      cnt_null_q    <= '0;
      stat_valid_q  <= 1'b0;
      stat_data_q   <= '0;
      stat_pilot_q  <= '0;
      stat_null_q   <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      start_err_q   <= start_err_d;
      bw_q          <= bw_d;
      scan_bank_q   <= scan_bank_d;
      active_bank_q <= active_bank_d;
      commit_pend_q <= commit_pend_d;
      rd_ptr_q      <= rd_ptr_d;
      s1_v_q        <= s1_v_d;
      s1_addr_q     <= s1_addr_d;
      o_valid_q     <= o_valid_d;
      o_cls_q       <= o_cls_d;
      o_addr_q      <= o_addr_d;
      o_sop_q       <= o_sop_d;
      o_eop_q       <= o_eop_d;
      cnt_data_q    <= cnt_data_d;
      cnt_pilot_q   <= cnt_pilot_d;
      cnt_null_q    <= cnt_null_d;
      stat_valid_q  <= stat_valid_d;
      stat_data_q   <= stat_data_d;
      stat_pilot_q  <= stat_pilot_d;
      stat_null_q   <= stat_null_d;
    end
  end

  assign busy        = busy_q;
  assign start_err   = start_err_q;
  assign commit_pend = commit_pend_q;
  assign active_bank = active_bank_q;
  assign o_valid     = o_valid_q;
  assign o_cls       = o_cls_q;
  assign o_addr      = o_addr_q;
  assign o_sop       = o_sop_q;
  assign o_eop       = o_eop_q;
  assign stat_valid  = stat_valid_q;
  assign stat_data   = stat_data_q;
  assign stat_pilot  = stat_pilot_q;
  assign stat_null   = stat_null_q;

endmodule

// File: tb/tb_ofdm_map_seq.sv
// tb/tb_ofdm_map_seq.sv - randomized self-checking bench for ofdm_map_seq
// Expected streams come from a two-bank array model of the map and the bank-swap rules.
module tb_ofdm_map_seq;

  localparam int FFTSIZE = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_BW  = 6;
  localparam int CLS_W   = 2;
  localparam int BW_W    = 3;
  localparam int WORD_W  = NUM_BW * CLS_W;
  localparam int CNT_W   = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [BW_W-1:0]   bw_idx = '0;
  logic              busy, start_err, commit_pend, active_bank;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [WORD_W-1:0] cfg_wdata = '0;
  logic              cfg_commit = 1'b0;
  logic              o_valid, o_sop, o_eop, stat_valid;
  logic              o_ready = 1'b1;
  logic [CLS_W-1:0]  o_cls;
  logic [ADDR_W-1:0] o_addr;
  logic [CNT_W-1:0]  stat_data, stat_pilot, stat_null;

  int n_checks = 0;
  int n_errors = 0;
  logic [WORD_W-1:0] mem_m [2][FFTSIZE];
  int active_m = 0;

  ofdm_map_seq #(
    .FFTSIZE(FFTSIZE), .ADDR_W(ADDR_W), .NUM_BW(NUM_BW), .CLS_W(CLS_W), .BW_W(BW_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bw_idx(bw_idx), .busy(busy), .start_err(start_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .commit_pend(commit_pend), .active_bank(active_bank), .o_valid(o_valid), .o_ready(o_ready),
    .o_cls(o_cls), .o_addr(o_addr), .o_sop(o_sop), .o_eop(o_eop), .stat_valid(stat_valid),
    .stat_data(stat_data), .stat_pilot(stat_pilot), .stat_null(stat_null)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: field 0 = n%4, other fields random; mode 1: every field is data
  task automatic write_shadow(input int mode);
    for (int a = 0; a < FFTSIZE; a++) begin
      logic [WORD_W-1:0] w;
      if (mode == 0) begin
        w = WORD_W'($urandom);
        w[1:0] = 2'(a % 4);
      end else begin
        w = {NUM_BW{2'b01}};
      end
      cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_wdata = w;
      mem_m[1-active_m][a] = w;
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic idle_commit();
    int old;
    old = active_m;
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("commit_pend_set", {commit_pend, active_bank}, {1'b1, 1'(old)});
    @(negedge clk);
    chk("idle_swap", {commit_pend, active_bank}, {1'b0, 1'(1 - old)});
    active_m = 1 - old;
  endtask

  task automatic bad_start(input int bw);
    start = 1'b1; bw_idx = BW_W'(bw);
    @(negedge clk);
    start = 1'b0;
    chk("start_err_pulse", {start_err, busy, o_valid}, 3'b100);
    @(negedge clk);
    chk("start_err_clear", {start_err, busy, o_valid}, 3'b000);
  endtask

  // ev_kind: 0 none, 1 shadow writes + commit, 2 start while busy, 3 reset at beat ev_beat
  task automatic scan(input int bw, input bit rand_ready, input int ev_kind, input int ev_beat);
    logic [CLS_W-1:0] exp_cls [FFTSIZE];
    int exp_d, exp_p, exp_n, bank, beats, stats, first_n, n;
    bit held, ev_done, post_ev, aborted;
    logic [8:0] held_v;
    exp_d = 0; exp_p = 0; exp_n = 0; bank = active_m;
    beats = 0; stats = 0; first_n = -1;
    held = 1'b0; ev_done = 1'b0; post_ev = 1'b0; aborted = 1'b0; held_v = '0;
    for (int a = 0; a < FFTSIZE; a++) begin
      exp_cls[a] = CLS_W'((mem_m[bank][a] >> (bw * CLS_W)) & 3);
      if (exp_cls[a] == 1) exp_d++;
      else if (exp_cls[a] == 2) exp_p++;
      else exp_n++;
    end
    start = 1'b1; bw_idx = BW_W'(bw); o_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {busy, o_valid}, 2'b10);
    n = 1;
    while (n < 300 && stats == 0 && !aborted) begin
      start = 1'b0; cfg_commit = 1'b0; cfg_we = 1'b0;
      if (held) chk("hold_stable", {o_valid, o_addr, o_cls, o_sop, o_eop}, held_v);
      if (post_ev) begin
        post_ev = 1'b0;
        if (ev_kind == 1) chk("commit_pend_mid", commit_pend, 1);
        if (ev_kind == 2) chk("start_busy_ignored", {start_err, busy}, 2'b01);
      end
      if (o_valid && first_n < 0) first_n = n;
      if (stat_valid) begin
        stats++;
        chk("stat_data", stat_data, exp_d);
        chk("stat_pilot", stat_pilot, exp_p);
        chk("stat_null", stat_null, exp_n);
        chk("busy_at_stat", {busy, o_valid}, 2'b00);
        chk("beats_at_stat", beats, FFTSIZE);
        if (ev_kind == 1) chk("pend_at_stat", {commit_pend, active_bank}, {1'b1, 1'(bank)});
      end else begin
        if (!ev_done && ev_kind != 0 && beats >= ev_beat) begin
          ev_done = 1'b1;
          post_ev = 1'b1;
          if (ev_kind == 1) cfg_commit = 1'b1;
          if (ev_kind == 2) begin
            start = 1'b1;
            bw_idx = BW_W'($urandom_range(0, NUM_BW - 1));
          end
          if (ev_kind == 3) begin
            rst = 1'b1;
            #1;
            chk("rst_mid_scan", {o_valid, busy, stat_valid}, 3'b000);
            aborted = 1'b1;
          end
        end
        if (!aborted) begin
          if (ev_kind == 1 && n <= FFTSIZE) begin
            cfg_we = 1'b1; cfg_addr = ADDR_W'(n - 1); cfg_wdata = {NUM_BW{2'b01}};
            mem_m[1-active_m][n-1] = {NUM_BW{2'b01}};
          end
          o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (o_valid && o_ready) begin
            if (beats < FFTSIZE)
              chk("beat", {o_addr, o_cls, o_sop, o_eop},
                  {ADDR_W'(beats), exp_cls[beats], beats == 0, beats == FFTSIZE - 1});
            else
              chk("extra_beat", beats, FFTSIZE - 1);
            beats++;
          end
          held = o_valid && !o_ready;
          held_v = {o_valid, o_addr, o_cls, o_sop, o_eop};
        end
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; cfg_commit = 1'b0; cfg_we = 1'b0; o_ready = 1'b1;
    if (aborted) begin
      int noisy;
      noisy = 0;
      rst = 1'b0;
      active_m = 0;
      chk("beats_before_rst", beats, ev_beat);
      chk("rst_bank_state", {commit_pend, active_bank}, 2'b00);
      for (int i = 0; i < 4; i++) begin
        if (stat_valid || o_valid || busy) noisy++;
        @(negedge clk);
      end
      chk("post_rst_quiet", noisy, 0);
    end else begin
      chk("stat_pulses", stats, 1);
      chk("first_valid_latency", first_n, 2);
      chk("stat_pulse_len", stat_valid, 0);
      chk("stat_hold", {stat_data, stat_pilot, stat_null},
          {CNT_W'(exp_d), CNT_W'(exp_p), CNT_W'(exp_n)});
      if (ev_kind == 1) begin
        chk("swap_after_stat", {commit_pend, active_bank}, {1'b0, 1'(1 - bank)});
        active_m = 1 - bank;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_valid, busy, start_err, stat_valid, commit_pend, active_bank}, 6'b0);
    chk("reset_stats", {stat_data, stat_pilot, stat_null}, '0);
    rst = 1'b0;
    @(negedge clk);

    write_shadow(0);
    idle_commit();
    write_shadow(0);

    scan(0, 1'b0, 0, 0);
    chk("pattern_counts", {stat_data, stat_pilot, stat_null}, {CNT_W'(4), CNT_W'(4), CNT_W'(8)});
    scan(0, 1'b1, 0, 0);

    bad_start(6);
    bad_start(7);

    scan($urandom_range(0, NUM_BW - 1), 1'b1, 1, 5);
    scan($urandom_range(0, NUM_BW - 1), 1'b1, 0, 0);
    chk("all_data_symbol", stat_data, FFTSIZE);

    write_shadow(0);
    idle_commit();
    scan($urandom_range(0, NUM_BW - 1), 1'b1, 3, 7);
    scan($urandom_range(0, NUM_BW - 1), 1'b0, 0, 0);

    scan($urandom_range(0, NUM_BW - 1), 1'b1, 2, 4);

    for (int k = 0; k < 3; k++) begin
      write_shadow(0);
      idle_commit();
      scan($urandom_range(0, NUM_BW - 1), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
